mio_bus_ctrl: RTL and testbench

- Parametrised, registered successor to the combinational MIO address decoder; sits between the CPU data port and up to NUM_SLAVES memory-mapped peripherals (data RAM, GPIO, counters, display, accelerators).
- Decodes a configurable address-tag field and runs a request/acknowledge transaction with each slave, so slow peripherals can insert wait states.
- Flags unmapped or timed-out accesses as bus errors and keeps a saturating error count.

---
 rtl/mio_bus_pkg.sv | 29 ++
 rtl/mio_bus_ctrl_decode.sv | 23 ++
 rtl/mio_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_pkg.sv
// Shared types and helpers for the MIO bus controller.
// Holds the FSM encoding, error-response constants and the tag/counter helpers.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int ADDR_MAX_W = 64;
  localparam int DATA_MAX_W = 64;

  localparam logic [DATA_MAX_W-1:0] ERR_RDATA     = 64'd0;
  localparam logic [7:0]            ERR_COUNT_MAX = 8'hFF;

  // Right-aligns the tag field; the caller truncates to the tag width.
  function automatic logic [ADDR_MAX_W-1:0] tag_field(
    input logic [ADDR_MAX_W-1:0] addr,
    input int unsigned           tag_lo
  );
    return addr >> tag_lo;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == ERR_COUNT_MAX) ? ERR_COUNT_MAX : value + 8'd1;
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_decode.sv
// Combinational priority tag decoder: the lowest-numbered matching slot wins.
module mio_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int TW         = 4,
  parameter int IDX_W      = 2
) (
  input  logic [TW-1:0]            tag,
  input  logic [NUM_SLAVES*TW-1:0] slv_tags,
  output logic [IDX_W-1:0]         idx,
  output logic                     hit
);

  // Scan from the top slot down so lower slots overwrite higher ones.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      idx = (slv_tags[i*TW +: TW] == tag) ? IDX_W'(i) : idx;
      hit = (slv_tags[i*TW +: TW] == tag) | hit;
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered MIO bus controller: decodes the address tag, runs a req/ack
// handshake with the selected slave and reports unmapped/timed-out accesses.
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_HI     = 31,
  parameter int TAG_LO     = 28,
  parameter logic [NUM_SLAVES*(TAG_HI-TAG_LO+1)-1:0] SLV_TAGS = {4'hf, 4'he, 4'hd, 4'h0},
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        slv_sel,
  output logic                         slv_we,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ack,
  output logic [7:0]                   err_count,
  output logic                         busy
);

  localparam int TW    = TAG_HI - TAG_LO + 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [NUM_SLAVES-1:0] SEL_ONE  = NUM_SLAVES'(1'b1);
  localparam logic [7:0]            LAST_CNT = 8'(TIMEOUT - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx_lat;
  logic                we_lat;
  logic [7:0]          wait_cnt;

  logic [TW-1:0]       tag;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_hit;
  logic [DATA_W-1:0]   ack_rdata;
  logic                ack_seen;

  assign tag = TW'(tag_field(ADDR_MAX_W'(cpu_addr), TAG_LO));

  mio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .TW         (TW),
    .IDX_W      (IDX_W)
  ) u_decode (
    .tag      (tag),
    .slv_tags (SLV_TAGS),
    .idx      (dec_idx),
    .hit      (dec_hit)
  );

  // Only the latched slot's ack and data are observed; other slots are ignored.
  always_comb begin
    ack_seen  = slv_ack[idx_lat];
    ack_rdata = slv_rdata[int'(idx_lat)*DATA_W +: DATA_W];
  end

  assign busy = (state != IDLE);

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx_lat   <= '0;
      we_lat    <= 1'b0;
      wait_cnt  <= 8'd0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      err_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          if (cpu_req) begin
            we_lat    <= cpu_we;
            slv_addr  <= cpu_addr;
            slv_wdata <= cpu_wdata;
            idx_lat   <= dec_idx;
            wait_cnt  <= 8'd0;
            if (dec_hit) begin
              state   <= ACCESS;
              slv_sel <= SEL_ONE << dec_idx;
              slv_we  <= cpu_we;
            end else begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= DATA_W'(ERR_RDATA);
              err_count <= sat_inc8(err_count);
            end
          end else begin
            state <= IDLE;
          end
        end

        ACCESS: begin
          if (ack_seen) begin
            state     <= RESP;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b0;
            cpu_rdata <= we_lat ? DATA_W'(ERR_RDATA) : ack_rdata;
          end else if (wait_cnt == LAST_CNT) begin
            state     <= RESP;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= DATA_W'(ERR_RDATA);
            err_count <= sat_inc8(err_count);
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          slv_sel   <= '0;
          slv_we    <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          slv_sel   <= '0;
          slv_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed self-checking bench for mio_bus_ctrl; slot tags are ordered so that
// tag F -> slot 0, E -> slot 1, D -> slot 2, 0 -> slot 3.
module tb_mio_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_err;
  logic [3:0]   slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ack;
  logic [7:0]   err_count;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  mio_bus_ctrl #(
    .NUM_SLAVES (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .TAG_HI     (31),
    .TAG_LO     (28),
    .SLV_TAGS   (16'h0DEF),
    .TIMEOUT    (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .slv_sel   (slv_sel),
    .slv_we    (slv_we),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ack   (slv_ack),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one access from an IDLE negedge. ack_slot < 0 means no ack;
  // stray_slot acks for one cycle mid-wait; busy_pulse fires a req during ACCESS.
  task automatic run_access(
    input string       name,
    input logic [31:0] addr,
    input logic        we,
    input logic [31:0] wdata,
    input int          ack_slot,
    input int          ack_delay,
    input int          stray_slot,
    input logic        busy_pulse,
    input int          exp_lat,
    input logic        exp_err,
    input logic [31:0] exp_rdata,
    input logic [3:0]  exp_sel,
    input int          exp_sel_cycles
  );
    int          lat = 0;
    int          sel_cycles = 0;
    int          bad = 0;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = 32'd0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) cpu_req = 1'b0;
      if (cpu_ready) begin
        lat       = k;
        got_err   = cpu_err;
        got_rdata = cpu_rdata;
        break;
      end
      if (slv_sel != 4'd0) begin
        sel_cycles++;
        if (slv_sel != exp_sel || slv_we != we || slv_wdata != wdata || slv_addr != addr) bad++;
      end else if (slv_we != 1'b0) begin
        bad++;
      end
      slv_ack = 4'd0;
      if (ack_slot >= 0 && k >= 1 + ack_delay) slv_ack[ack_slot] = 1'b1;
      if (stray_slot >= 0 && k == 3) slv_ack[stray_slot] = 1'b1;
      if (busy_pulse && k == 2) begin
        cpu_req  = 1'b1;
        cpu_addr = 32'h3000_0000;
      end else if (busy_pulse && k == 3) begin
        cpu_req  = 1'b0;
        cpu_addr = addr;
      end
    end
    slv_ack = 4'd0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " err"}, 64'(got_err), 64'(exp_err));
    check({name, " rdata"}, 64'(got_rdata), 64'(exp_rdata));
    check({name, " sel_cycles"}, 64'(sel_cycles), 64'(exp_sel_cycles));
    check({name, " sel_we_data"}, 64'(bad), 64'd0);
    @(negedge clk);
    check({name, " ready_pulse"}, 64'({cpu_ready, cpu_err, busy}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int readies;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    slv_ack   = 4'd0;
    slv_rdata = {32'h1234_5678, 32'h5555_AAAA, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    repeat (3) @(negedge clk);
    check("reset outputs", 64'({cpu_ready, cpu_err, slv_sel, slv_we, busy}), 64'd0);
    check("reset data", 64'({cpu_rdata, slv_addr}), 64'd0);
    check("reset wdata_cnt", 64'({slv_wdata, err_count}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access("rd_slot3", 32'h0000_0010, 1'b0, 32'd0, 3, 0, -1, 1'b0,
               2, 1'b0, 32'h1234_5678, 4'b1000, 1);
    run_access("wr_slot1", 32'hE000_0000, 1'b1, 32'hA5A5_A5A5, 1, 3, -1, 1'b1,
               5, 1'b0, 32'd0, 4'b0010, 4);
    check("busy_req_dropped", 64'(err_count), 64'd0);
    run_access("unmapped", 32'h3000_0000, 1'b0, 32'd0, -1, 0, -1, 1'b0,
               1, 1'b1, 32'd0, 4'b0000, 0);
    check("err_count_1", 64'(err_count), 64'd1);
    run_access("timeout", 32'hF000_0004, 1'b0, 32'd0, -1, 0, 2, 1'b0,
               16, 1'b1, 32'd0, 4'b0001, 15);
    check("err_count_2", 64'(err_count), 64'd2);

    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'hF000_0004;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_sel", 64'(slv_sel), 64'b0001);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", 64'({cpu_ready, slv_sel, busy}), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    run_access("after_rst", 32'hE000_0008, 1'b0, 32'd0, 1, 0, -1, 1'b0,
               2, 1'b0, 32'hCAFE_F00D, 4'b0010, 1);

    readies = 0;
    for (int i = 1; i <= 256; i++) begin
      cpu_req  = 1'b1;
      cpu_addr = 32'h3000_0000;
      @(negedge clk);
      cpu_req = 1'b0;
      if (cpu_ready && cpu_err) readies++;
      @(negedge clk);
      if (i == 255) check("err_count_255", 64'(err_count), 64'hFF);
    end
    check("sat_readies", 64'(readies), 64'd256);
    check("err_count_sat", 64'(err_count), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
